// File: rtl/matmul_sched.sv
// Address scheduler for a 64x64 by 64 multiply-sum: issues paired M/X ROM reads per lane,
// then waits out ROM latency so the external summer sees every lane product exactly once.
module matmul_sched #(
  parameter int LANES   = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   but0,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [LANES-1:0][11:0] m_addr_a,
  output logic [LANES-1:0][11:0] m_addr_b,
  output logic [LANES-1:0][5:0]  x_addr_a,
  output logic [LANES-1:0][5:0]  x_addr_b,
  output logic                   acc_clr,
  output logic                   acc_en,
  output logic [15:0]            cycles
);

  localparam int BEATS = 4096 / (2 * LANES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [11:0]            k_q, k_d;
  logic [1:0]             drn_q, drn_d;
  logic [ROM_LAT-1:0]     dly_q, dly_d;
  logic [15:0]            cycles_q, cycles_d, cycles_inc;
  logic                   busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [LANES-1:0][11:0] m_a_q, m_a_d, m_b_q, m_b_d;
  logic                   idle_like;

  assign idle_like  = (state_q == IDLE) || (state_q == DONE);
  assign acc_clr    = !but0 && start && idle_like;
  assign cycles_inc = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    drn_d    = drn_q;
    cycles_d = cycles_q;
    dly_d    = ROM_LAT'({dly_q, rd_en_q});
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = ISSUE;
          k_d      = 12'd0;
          cycles_d = 16'd0;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
          dly_d   = '0;
        end else begin
          cycles_d = cycles_inc;
          if (k_q == 12'(BEATS - 1)) begin
            state_d = DRAIN;
            drn_d   = 2'd0;
          end else begin
            k_d = k_q + 12'd1;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          dly_d   = '0;
        end else begin
          cycles_d = cycles_inc;
          if (drn_q == 2'(ROM_LAT - 1)) state_d = DONE;
          else                          drn_d   = drn_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are computed from the next state.
    busy_d  = (state_d == ISSUE) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
    rd_en_d = (state_d == ISSUE);
    for (int i = 0; i < LANES; i++) begin
      m_a_d[i] = '0;
      m_b_d[i] = '0;
      if (rd_en_d) begin
        m_a_d[i] = 12'(k_d * 12'(2 * LANES)) + 12'(2 * i);
        m_b_d[i] = m_a_d[i] + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge but0) begin
    if (but0) begin
      state_q  <= IDLE;
      k_q      <= '0;
      drn_q    <= '0;
      dly_q    <= '0;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      m_a_q    <= '0;
      m_b_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      drn_q    <= drn_d;
      dly_q    <= dly_d;
      cycles_q <= cycles_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      m_a_q    <= m_a_d;
      m_b_q    <= m_b_d;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      x_addr_a[i] = m_a_q[i][5:0];
      x_addr_b[i] = m_b_q[i][5:0];
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign m_addr_a = m_a_q;
  assign m_addr_b = m_b_q;
  assign acc_en   = dly_q[ROM_LAT-1];
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Bench for matmul_sched: ROM_LAT=1 instance with address scoreboard and summer model,
// ROM_LAT=3 instance for reset-during-drain.
module tb_matmul_sched;

  localparam int L = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, start1, abort1, busy1, done1, rd1, clr1, acc1;
  logic [L-1:0][11:0] ma1, mb1;
  logic [L-1:0][5:0]  xa1, xb1;
  logic [15:0]        cyc1;

  logic rst3, start3, abort3, busy3, done3, rd3, clr3, acc3;
  logic [L-1:0][11:0] ma3, mb3;
  logic [L-1:0][5:0]  xa3, xb3;
  logic [15:0]        cyc3;

  matmul_sched #(.LANES(L), .ROM_LAT(1)) dut (
    .clk(clk), .but0(rst1), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .rd_en(rd1),
    .m_addr_a(ma1), .m_addr_b(mb1), .x_addr_a(xa1), .x_addr_b(xb1),
    .acc_clr(clr1), .acc_en(acc1), .cycles(cyc1));

  matmul_sched #(.LANES(L), .ROM_LAT(3)) dut3 (
    .clk(clk), .but0(rst3), .start(start3), .abort(abort3),
    .busy(busy3), .done(done3), .rd_en(rd3),
    .m_addr_a(ma3), .m_addr_b(mb3), .x_addr_a(xa3), .x_addr_b(xb3),
    .acc_clr(clr3), .acc_en(acc3), .cycles(cyc3));

  int           errors = 0;
  int           checks = 0;
  logic [287:0] sb[$];
  int           rd_cnt1 = 0, acc_cnt1 = 0, rd_cnt3 = 0, acc_cnt3 = 0;
  logic [15:0]  sum1 = '0;
  logic         exp_acc1 = 1'b0;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [287:0] beat_vec(input int k);
    logic [L-1:0][11:0] a, b;
    logic [L-1:0][5:0]  xa, xb;
    for (int i = 0; i < L; i++) begin
      a[i]  = 12'(2 * L * k + 2 * i);
      b[i]  = 12'(2 * L * k + 2 * i + 1);
      xa[i] = a[i][5:0];
      xb[i] = b[i][5:0];
    end
    return {a, b, xa, xb};
  endfunction

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    logic [287:0] e;
    @(negedge clk);
    if (!rst1) begin
      if (start1 && !busy1) begin
        sum1 = '0; acc_cnt1 = 0; rd_cnt1 = 0;
        for (int k = 0; k < 4096 / (2 * L); k++) sb.push_back(beat_vec(k));
      end
      check("acc_en_timing", 320'(acc1), 320'(exp_acc1));
      if (acc1) begin
        acc_cnt1++;
        sum1 += 16'(2 * L);
      end
      if (rd1) begin
        if (rd_cnt1 == 0) begin
          check("beat0_lane3_ma", 320'(ma1[3]), 320'(12'd6));
          check("beat0_lane3_mb", 320'(mb1[3]), 320'(12'd7));
          check("beat0_lane3_xa", 320'(xa1[3]), 320'(6'd6));
        end
        if (rd_cnt1 == 255) begin
          check("beat255_lane7_mb", 320'(mb1[7]), 320'(12'd4095));
          check("beat255_lane7_xb", 320'(xb1[7]), 320'(6'd63));
        end
        rd_cnt1++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $error("FAIL sb_underflow: observed rd_en=1 with no expected beat, required none");
        end else begin
          e = sb.pop_front();
          check("addr_beat", 320'({ma1, mb1, xa1, xb1}), 320'(e));
        end
      end
      if (abort1 && busy1) sb.delete();
      exp_acc1 = rd1 && !(abort1 && busy1);
    end else begin
      exp_acc1 = 1'b0;
    end
    if (!rst3) begin
      if (start3 && !busy3) begin
        rd_cnt3 = 0; acc_cnt3 = 0;
      end
      if (rd3)  rd_cnt3++;
      if (acc3) acc_cnt3++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done1(input string tag);
    for (int n = 0; n < 600 && !done1; n++) tick();
    check(tag, 320'(done1), 320'(1'b1));
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy",   320'(busy1), 320'(1'b0));
    check("rst_done",   320'(done1), 320'(1'b0));
    check("rst_rd_en",  320'(rd1),   320'(1'b0));
    check("rst_acc_en", 320'(acc1),  320'(1'b0));
    check("rst_cycles", 320'(cyc1),  320'(16'h0000));
    check("rst_addr",   320'({ma1, mb1, xa1, xb1}), 320'(0));
    start1 = 1'b1;
    #1;
    check("rst_acc_clr", 320'(clr1), 320'(1'b0));
    start1 = 1'b0;
    rst1 = 1'b0; rst3 = 1'b0;
    tick(); tick();
    check("idle_busy", 320'(busy1), 320'(1'b0));

    // Full pass from IDLE
    start1 = 1'b1;
    #1;
    check("clr_from_idle", 320'(clr1), 320'(1'b1));
    tick();
    start1 = 1'b0;
    check("issue_busy",   320'(busy1), 320'(1'b1));
    check("issue_cycles", 320'(cyc1),  320'(16'h0000));
    wait_done1("pass1_done");
    check("pass1_rd",     320'(rd_cnt1),  320'(256));
    check("pass1_acc",    320'(acc_cnt1), 320'(256));
    check("pass1_cycles", 320'(cyc1),     320'(16'h0101));
    check("pass1_sum",    320'(sum1),     320'(16'h1000));
    check("pass1_busy",   320'(busy1),    320'(1'b0));
    check("pass1_sb",     320'(sb.size()), 320'(0));
    tick(); tick();
    check("done_hold", 320'(done1), 320'(1'b1));
    check("done_addr", 320'({ma1, mb1, xa1, xb1}), 320'(0));

    // Restart from DONE
    start1 = 1'b1;
    #1;
    check("clr_from_done", 320'(clr1), 320'(1'b1));
    tick();
    start1 = 1'b0;
    check("restart_done_low", 320'(done1), 320'(1'b0));
    wait_done1("pass2_done");
    check("pass2_sum",    320'(sum1), 320'(16'h1000));
    check("pass2_cycles", 320'(cyc1), 320'(16'h0101));

    // Abort at beat 100
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n < 300 && rd_cnt1 != 100; n++) tick();
    check("abort_beat", 320'(ma1[0]), 320'(12'd1600));
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check("abort_busy",   320'(busy1), 320'(1'b0));
    check("abort_done",   320'(done1), 320'(1'b0));
    check("abort_rd_en",  320'(rd1),   320'(1'b0));
    check("abort_cycles", 320'(cyc1),  320'(16'd100));
    for (int n = 0; n < 5; n++) tick();
    check("abort_acc",     320'(acc_cnt1),  320'(100));
    check("abort_cycles2", 320'(cyc1),      320'(16'd100));
    check("abort_sb",      320'(sb.size()), 320'(0));
    check("abort_done2",   320'(done1),     320'(1'b0));

    // Abort in IDLE is ignored; abort beats start while busy
    start1 = 1'b1; abort1 = 1'b1;
    tick();
    check("idle_abort_start", 320'(busy1), 320'(1'b1));
    abort1 = 1'b0;
    tick(); tick();
    abort1 = 1'b1;
    #1;
    check("busy_no_clr", 320'(clr1), 320'(1'b0));
    tick();
    start1 = 1'b0; abort1 = 1'b0;
    check("abort_over_start", 320'(busy1), 320'(1'b0));
    tick();
    check("abort_stays_idle", 320'(done1 | busy1), 320'(1'b0));

    // Start held high: one new pass per DONE entry
    start1 = 1'b1;
    tick();
    wait_done1("held1_done");
    check("held1_cycles", 320'(cyc1),     320'(16'h0101));
    check("held1_acc",    320'(acc_cnt1), 320'(256));
    check("held1_rd",     320'(rd_cnt1),  320'(256));
    tick();
    start1 = 1'b0;
    check("held_restart", 320'(busy1), 320'(1'b1));
    check("held_cycles0", 320'(cyc1),  320'(16'h0000));
    wait_done1("held2_done");
    check("held2_sum", 320'(sum1), 320'(16'h1000));
    tick(); tick();
    check("held2_stay", 320'(done1), 320'(1'b1));
    check("held_sb",    320'(sb.size()), 320'(0));

    // ROM_LAT=3: reset in DRAIN, then a fresh pass
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int n = 0; n < 600 && !(busy3 && !rd3); n++) tick();
    check("drain_reached", 320'(busy3 && !rd3), 320'(1'b1));
    tick();
    rst3 = 1'b1;
    #1;
    check("drain_rst_busy", 320'(busy3), 320'(1'b0));
    check("drain_rst_done", 320'(done3), 320'(1'b0));
    check("drain_rst_acc",  320'(acc3),  320'(1'b0));
    check("drain_rst_rd",   320'(rd3),   320'(1'b0));
    check("drain_rst_cyc",  320'(cyc3),  320'(16'h0000));
    check("drain_rst_addr", 320'({ma3, mb3, xa3, xb3}), 320'(0));
    start3 = 1'b1;
    #1;
    check("drain_rst_clr", 320'(clr3), 320'(1'b0));
    start3 = 1'b0;
    rst3 = 1'b0;
    tick(); tick();
    check("after_rst_idle", 320'(busy3 | done3 | acc3), 320'(1'b0));
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int n = 0; n < 600 && !done3; n++) tick();
    check("lat3_done",   320'(done3),    320'(1'b1));
    check("lat3_rd",     320'(rd_cnt3),  320'(256));
    check("lat3_acc",    320'(acc_cnt3), 320'(256));
    check("lat3_cycles", 320'(cyc3),     320'(16'h0103));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_sched.md
MATMUL_SCHED -- requirements
Module: matmul_sched

Interface
REQ-001 SHALL have parameter LANES, default 8, number of two-product lanes (legal: 1, 2, 4, 8, 16).
REQ-002 SHALL have parameter ROM_LAT, default 1, cycles from address issue to ROM data (legal: 1..3).
REQ-003 SHALL have port clk  input  1  single system clock; all state on posedge clk.
REQ-004 SHALL have port but0  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request one full 64x64 by 64 multiply-sum pass.
REQ-006 SHALL have port abort  input  1  cancel an in-progress pass.
REQ-007 SHALL have port busy  output  1  high in ISSUE or DRAIN.
REQ-008 SHALL have port done  output  1  high in DONE.
REQ-009 SHALL have port rd_en  output  1  ROM read-enable; addresses valid this cycle.
REQ-010 SHALL have port m_addr_a, m_addr_b  output  LANES x 12  per-lane M ROM port A/B addresses.
REQ-011 SHALL have port x_addr_a, x_addr_b  output  LANES x 6  per-lane X ROM port A/B addresses.
REQ-012 SHALL have port acc_clr  output  1  one-cycle clear of the external running sum.
REQ-013 SHALL have port acc_en  output  1  lane products valid; external sum adds all lane results.
REQ-014 SHALL have port cycles  output  16  pass duration in clocks.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE; reset state IDLE.
REQ-016 SHALL use BEATS = 4096/(2*LANES) issue beats per pass (256 at LANES=8).
REQ-017 SHALL in IDLE or DONE accept start=1: acc_clr=1 that cycle; next state ISSUE, beat counter k=0, cycles=0.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL in ISSUE assert rd_en and drive, for lane i, m_addr_a=2*LANES*k+2i, m_addr_b=m_addr_a+1 (12-bit), x_addr_a/x_addr_b = low 6 bits of m_addr_a/m_addr_b.
REQ-020 SHALL increment k each ISSUE cycle; after beat BEATS-1 go to DRAIN.
REQ-021 SHALL drive addresses to 0 and rd_en=0 outside ISSUE.
REQ-022 SHALL assert acc_en exactly ROM_LAT cycles after each rd_en cycle (delay line of rd_en, depth ROM_LAT); exactly BEATS acc_en cycles per completed pass.
REQ-023 SHALL remain in DRAIN exactly ROM_LAT cycles, then enter DONE.
REQ-024 SHALL increment cycles once per cycle in ISSUE or DRAIN, saturating at 16'hFFFF; hold in IDLE/DONE until next accepted start.
REQ-025 SHALL hold done=1 in DONE until next accepted start; done and busy never both high.
REQ-026 SHALL on abort=1 in ISSUE or DRAIN go to IDLE next cycle, clear acc_en delay line that cycle (no acc_en afterwards), hold cycles; done stays 0.
REQ-027 SHALL give abort priority over start in the same cycle; abort in IDLE/DONE has no effect.
REQ-028 SHALL give every output registered timing except acc_clr (combinational from start and state).

Reset
REQ-029 SHALL on but0=1, immediately and independent of clk: state IDLE, k=0, delay line cleared, cycles=0, busy=0, done=0, rd_en=0, acc_en=0, all addresses 0; acc_clr=0 while but0=1.
REQ-030 SHALL on but0 asserted mid-pass discard the pass entirely; first start after release begins a fresh pass.

Verification
REQ-031 SHALL cover: reset, start pulse (LANES=8, ROM_LAT=1) -> rd_en 256 cycles, acc_en 256 cycles offset by 1, DONE, cycles=16'h0101.
REQ-032 SHALL cover: beat 0 lane 3 -> m_addr_a=6, m_addr_b=7, x_addr_a=6; beat 255 lane 7 -> m_addr_b=4095, x_addr_b=63.
REQ-033 SHALL cover: ROM with all bytes 1, external summer -> total 16'h1000; repeat start from DONE -> acc_clr pulse, same total.
REQ-034 SHALL cover: abort at ISSUE beat 100 -> IDLE next cycle, acc_en count 100, done=0, cycles=100.
REQ-035 SHALL cover: start held high throughout pass -> no restart until DONE, then one new pass per DONE entry.
REQ-036 SHALL cover: but0 pulse mid-DRAIN (ROM_LAT=3) -> all outputs 0 asynchronously; new start yields full 256-beat pass, cycles=16'h0103.
